dispselect: RTL and testbench

DISPSELECT -- requirements
Module: dispselect

---
 rtl/dispselect.sv | 72 +++++++
 tb/tb_dispselect.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispselect.sv
// dispselect: free-running digit-select scanner for a multiplexed display.
// A prescaler divides CLK by SCAN_DIV; each prescaler wrap advances a 2-bit
// scan state that is presented on D_OUT from a register.
// Optional build macro: DISPSELECT_GRAY_EN -- when defined, D_OUT walks the
// Gray sequence 00,01,11,10; otherwise it walks the binary sequence 00..11.
module dispselect #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [1:0] D_OUT
);

  // Terminal prescaler count; reaching it produces the step tick.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  // Power-up values keep D_OUT at 00 even if RST is never asserted.
  logic [CNT_W-1:0] pcnt_reg = '0;
  logic [CNT_W-1:0] pcnt_next;
  logic [1:0]       sel_reg  = 2'b00;
  logic [1:0]       sel_next;
  logic [1:0]       dout_reg = 2'b00;
  logic [1:0]       dout_next;
  logic             tick;

  // Map a scan state onto the pattern presented on D_OUT.
  function automatic logic [1:0] encode(input logic [1:0] s);
`ifdef DISPSELECT_GRAY_EN
    return {s[1], s[1] ^ s[0]};
`else
    return s;
`endif
  endfunction

  // Prescaler: count up to LAST, then wrap and tick. An out-of-range value
  // (only reachable through corruption) is discarded without a tick.
  always_comb begin
    tick      = 1'b0;
    pcnt_next = pcnt_reg + CNT_W'(1);
    if (pcnt_reg == LAST) begin
      tick      = 1'b1;
      pcnt_next = '0;
    end else if (32'(pcnt_reg) >= SCAN_DIV) begin
      pcnt_next = '0;
    end
  end

  // Scan state advances once per tick and wraps 3 -> 0 naturally; the
  // output register is loaded with the encoded next state so D_OUT tracks
  // SEL on the same edge without any combinational path to the pin.
  always_comb begin
    sel_next  = tick ? (sel_reg + 2'd1) : sel_reg;
    dout_next = encode(sel_next);
  end

  // State registers with synchronous reset that overrides any tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt_reg <= '0;
      sel_reg  <= 2'b00;
      dout_reg <= 2'b00;
    end else begin
      pcnt_reg <= pcnt_next;
      sel_reg  <= sel_next;
      dout_reg <= dout_next;
    end
  end

  assign D_OUT = dout_reg;

endmodule

// File: tb/tb_dispselect.sv
// tb_dispselect: self-checking bench for dispselect. Two instances share
// clock and reset: SCAN_DIV=4 (default) and SCAN_DIV=1. Expected outputs come
// from a counter of reset-free edges: step = (edges / SCAN_DIV) mod 4.
module tb_dispselect;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] d4;
  logic [1:0] d1;

  int unsigned n = 0;      // edges with RST low since last reset edge / power-up
  int checks = 0;
  int passed = 0;

  logic [1:0] seq [0:4];   // expected visible sequence, one entry per step

  dispselect #(.SCAN_DIV(DIV), .CNT_W(16)) dut (
    .CLK  (clk),
    .RST  (rst),
    .D_OUT(d4)
  );

  dispselect #(.SCAN_DIV(1), .CNT_W(1)) dut1 (
    .CLK  (clk),
    .RST  (rst),
    .D_OUT(d1)
  );

  always #5 clk = ~clk;

  // Reference model: only counts reset-free edges.
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  function automatic logic [1:0] exp_out(input int unsigned cnt, input int unsigned div);
    int unsigned s;
    s = (cnt / div) % 4;
`ifdef DISPSELECT_GRAY_EN
    case (s)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
`else
    return 2'(s);
`endif
  endfunction

  // Advance k clock edges and return on the following falling edge.
  task automatic tick_n(input int k);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_powerup;
    #1;
    checks++;
    if (d4 !== 2'b00) $display("FAIL powerup_t0_d4 got=%b exp=00", d4);
    else passed++;
    checks++;
    if (d1 !== 2'b00) $display("FAIL powerup_t0_d1 got=%b exp=00", d1);
    else passed++;
    for (int k = 1; k <= 4; k++) begin
      tick_n(1);
      checks++;
      if (d4 !== exp_out(n, DIV)) $display("FAIL powerup_d4 edge=%0d got=%b exp=%b", k, d4, exp_out(n, DIV));
      else passed++;
      checks++;
      if (d1 !== exp_out(n, 1)) $display("FAIL powerup_d1 edge=%0d got=%b exp=%b", k, d1, exp_out(n, 1));
      else passed++;
    end
    checks++;
    if (d4 !== 2'b01) $display("FAIL powerup_step4 got=%b exp=01", d4);
    else passed++;
    $display("powerup: d4=%b d1=%b after 4 edges without reset", d4, d1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick_n(2);
    checks++;
    if (d4 !== 2'b00) $display("FAIL reset_d4 got=%b exp=00", d4);
    else passed++;
    checks++;
    if (d1 !== 2'b00) $display("FAIL reset_d1 got=%b exp=00", d1);
    else passed++;
    $display("reset: d4=%b d1=%b", d4, d1);
  endtask

  task automatic test_sequence;
    logic [1:0] prev1;
    rst = 1'b0;
    prev1 = d1;
    for (int k = 1; k <= 16; k++) begin
      tick_n(1);
      if (k == 3 || (k % 4) == 0) begin
        checks++;
        if (d4 !== seq[k / 4]) $display("FAIL sequence_d4 edge=%0d got=%b exp=%b", k, d4, seq[k / 4]);
        else passed++;
        $display("sequence: edge=%0d d4=%b", k, d4);
      end
      checks++;
      if (d1 !== seq[k % 4]) $display("FAIL div1_d1 edge=%0d got=%b exp=%b", k, d1, seq[k % 4]);
      else passed++;
`ifdef DISPSELECT_GRAY_EN
      checks++;
      if ($countones(d1 ^ prev1) != 1) $display("FAIL gray_hamming_d1 edge=%0d prev=%b cur=%b", k, prev1, d1);
      else passed++;
`endif
      prev1 = d1;
    end
  endtask

  task automatic test_mid_reset;
    int unsigned target;
`ifdef DISPSELECT_GRAY_EN
    target = 3 * DIV + 2;
`else
    target = 2 * DIV + 2;
`endif
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    tick_n(int'(target));
    checks++;
    if (d4 !== 2'b10) $display("FAIL midreset_pre got=%b exp=10", d4);
    else passed++;
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    checks++;
    if (d4 !== 2'b00) $display("FAIL midreset_clear got=%b exp=00", d4);
    else passed++;
    for (int k = 1; k <= int'(DIV); k++) begin
      tick_n(1);
      checks++;
      if (k < int'(DIV)) begin
        if (d4 !== 2'b00) $display("FAIL midreset_hold edge=%0d got=%b exp=00", k, d4);
        else passed++;
      end else begin
        if (d4 !== 2'b01) $display("FAIL midreset_step edge=%0d got=%b exp=01", k, d4);
        else passed++;
      end
    end
    $display("midreset: first step after release d4=%b", d4);
  endtask

  task automatic test_glitch;
    for (int g = 0; g < 6; g++) begin
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      tick_n(1);
      checks++;
      if (d4 !== exp_out(n, DIV)) $display("FAIL glitch_d4 pulse=%0d got=%b exp=%b", g, d4, exp_out(n, DIV));
      else passed++;
      checks++;
      if (d1 !== exp_out(n, 1)) $display("FAIL glitch_d1 pulse=%0d got=%b exp=%b", g, d1, exp_out(n, 1));
      else passed++;
    end
    $display("glitch: d4=%b after 6 sub-cycle reset pulses", d4);
  endtask

  task automatic test_random;
    int unsigned bad = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 24) == 0);
      tick_n(1);
      checks++;
      if (d4 !== exp_out(n, DIV)) begin
        bad++;
        $display("FAIL random_d4 iter=%0d got=%b exp=%b", i, d4, exp_out(n, DIV));
      end else passed++;
      checks++;
      if (d1 !== exp_out(n, 1)) begin
        bad++;
        $display("FAIL random_d1 iter=%0d got=%b exp=%b", i, d1, exp_out(n, 1));
      end else passed++;
    end
    rst = 1'b0;
    $display("random: 400 cycles, %0d disagreements", bad);
  endtask

  task automatic test_long_run;
    int cnt [0:3];
    int run_len;
    int mx;
    int mn;
    logic [1:0] prev;
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    prev = d4;
    run_len = 1;
    cnt[d4]++;
    for (int i = 0; i < 1000; i++) begin
      tick_n(1);
      cnt[d4]++;
      checks++;
      if (d4 !== exp_out(n, DIV)) $display("FAIL long_d4 cycle=%0d got=%b exp=%b", i, d4, exp_out(n, DIV));
      else passed++;
      if (d4 === prev) begin
        run_len++;
      end else begin
        checks++;
        if (run_len != int'(DIV)) $display("FAIL long_hold cycle=%0d held=%0d exp=%0d", i, run_len, DIV);
        else passed++;
`ifdef DISPSELECT_GRAY_EN
        checks++;
        if ($countones(d4 ^ prev) != 1) $display("FAIL gray_hamming_d4 cycle=%0d prev=%b cur=%b", i, prev, d4);
        else passed++;
`endif
        run_len = 1;
        prev = d4;
      end
    end
    mx = cnt[0];
    mn = cnt[0];
    for (int v = 1; v < 4; v++) begin
      if (cnt[v] > mx) mx = cnt[v];
      if (cnt[v] < mn) mn = cnt[v];
    end
    checks++;
    if (mx - mn > int'(DIV)) $display("FAIL long_balance spread=%0d limit=%0d", mx - mn, DIV);
    else passed++;
    $display("long: counts %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3]);
  endtask

  initial begin
`ifdef DISPSELECT_GRAY_EN
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10; seq[4] = 2'b00;
`else
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11; seq[4] = 2'b00;
`endif
    test_powerup();
    test_reset();
    test_sequence();
    test_mid_reset();
    test_glitch();
    test_random();
    test_long_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached passed=%0d checks=%0d", passed, checks);
    $fatal(1);
  end

endmodule
